// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of grant_id / owner index; never narrower than one bit.
    function automatic int unsigned gid_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshake plus FIFO write port bundled for the arbiter.
interface fifo_write_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned GW = fifo_arb_pkg::gid_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_almost_full;
    logic                   fifo_write_en;
    logic [WIDTH-1:0]       fifo_write_data;
    logic [GW-1:0]          grant_id;
    logic                   busy;

    // Arbiter view: drives ready, FIFO write strobe/data and status.
    modport master (
        input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
        output req_ready, fifo_write_en, fifo_write_data, grant_id, busy
    );

    // Producer/FIFO view: the environment around the arbiter.
    modport slave (
        output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
        input  req_ready, fifo_write_en, fifo_write_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority picker: first set valid bit at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);

    // Scan offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        int unsigned cand;
        logic [PW-1:0] ci;
        any = |valid;
        idx = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            cand = (32'(ptr) + k - 1) % N_REQ;
            ci   = PW'(cand);
            if (valid[ci]) begin
                idx = ci;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    fifo_write_arbiter_if.master bus
);

    localparam int unsigned GW = gid_width(N_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_q, beat_d;

    logic             pick_any;
    logic [GW-1:0]    pick_idx;
    logic             own_valid;
    logic             own_last;
    logic [WIDTH-1:0] own_data;
    logic             xfer;
    logic [GW-1:0]    owner_next;
    logic [BW-1:0]    beat_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (GW)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Owner-side selection and the transfer qualifier.
    always_comb begin
        own_valid = bus.req_valid[owner_q];
        own_last  = bus.req_last[owner_q];
        own_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == GW'(i)) begin
                own_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        xfer       = (state_q == BURST) && own_valid && !bus.fifo_full;
        owner_next = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
        beat_inc   = beat_q + 1'b1;
    end

    // Outputs derive from registered state, so async reset clears them at once.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == BURST) begin
            bus.req_ready[owner_q] = !bus.fifo_full;
        end
        bus.fifo_write_en   = xfer;
        bus.fifo_write_data = xfer ? own_data : '0;
        bus.grant_id        = owner_q;
        bus.busy            = (state_q == BURST);
    end

    // Grant in IDLE; count beats and decide burst end in BURST.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any && !bus.fifo_almost_full) begin
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_d = beat_inc;
                    if (own_last || (beat_inc == BW'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_next;
                    end
                end else if (!own_valid) begin
                    // Owner went idle: give up the port; a full FIFO alone only stalls.
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

endmodule
